// File: rtl/apb_regdisp_root_bridge_if.sv
// apb_regdisp_root_bridge_if
//   APB3/APB4 completer-side bus bundle used by apb_regdisp_root_bridge.
//   master : drives psel/penable/pwrite/paddr/pwdata/pstrb, receives pready/prdata/pslverr
//   slave  : the bridge side of the same bundle
interface apb_regdisp_root_bridge_if #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH     = 32
);
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic                      pready;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_regdisp_root_bridge.sv
// apb_regdisp_root_bridge
//   Turns one APB transfer into a single reg_native_if request toward
//   regdisp_root_map and returns the response on pready/prdata/pslverr.
//   Handles APB phase sequencing, absolute address formation (paddr + BASE_ADDR),
//   write-strobe checking and an ack timeout. All outputs are registered.
// Ports
//   regdisp_root_map_clk / regdisp_root_map_rst_n : clock, async active-low reset
//   apb                                           : APB completer bundle (slave modport)
//   sw_soft_rst                                   : soft-reset request, re-timed onto
//                                                   upstream__regdisp_root_map__soft_rst
//   upstream__regdisp_root_map__*                 : request toward regdisp_root_map
//   regdisp_root_map__upstream__*                 : ack / err / read data back
module apb_regdisp_root_bridge #(
  parameter int unsigned           APB_ADDR_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH     = 64,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 64'h0000_0000_2000_0000,
  parameter int unsigned           TIMEOUT_CYCLES = 255
) (
  input  logic                     regdisp_root_map_clk,
  input  logic                     regdisp_root_map_rst_n,
  apb_regdisp_root_bridge_if.slave apb,
  input  logic                     sw_soft_rst,
  output logic                     upstream__regdisp_root_map__req_vld,
  output logic [ADDR_WIDTH-1:0]    upstream__regdisp_root_map__addr,
  output logic                     upstream__regdisp_root_map__wr_en,
  output logic                     upstream__regdisp_root_map__rd_en,
  output logic [DATA_WIDTH-1:0]    upstream__regdisp_root_map__wr_data,
  output logic                     upstream__regdisp_root_map__soft_rst,
  input  logic                     regdisp_root_map__upstream__ack_vld,
  input  logic                     regdisp_root_map__upstream__err,
  input  logic [DATA_WIDTH-1:0]    regdisp_root_map__upstream__rd_data
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_wr_q;

  logic               setup;
  logic               strb_err;
  logic               in_access;
  logic               ack;
  logic               timeout_hit;

  logic               req_vld_d;
  logic               pready_d;
  logic               pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_d;

  assign setup       = apb.psel & ~apb.penable;
  assign strb_err    = apb.pwrite & (apb.pstrb != '1);
  assign in_access   = (state_q == S_REQ) || (state_q == S_WAIT);
  assign ack         = regdisp_root_map__upstream__ack_vld;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  // State register
  always_ff @(posedge regdisp_root_map_clk or negedge regdisp_root_map_rst_n) begin
    if (!regdisp_root_map_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack always takes priority over the timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (setup) begin
          state_d = strb_err ? S_RESP : S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        if (ack || timeout_hit) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs. The response
  // fields are non-zero only in the cycle that enters RESP, so prdata/pslverr
  // read as 0 whenever pready is low and stray acks never reach them.
  always_comb begin
    req_vld_d = 1'b0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (setup) begin
          if (strb_err) begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            req_vld_d = 1'b1;
          end
        end
      end
      S_REQ, S_WAIT: begin
        if (ack) begin
          pready_d  = 1'b1;
          pslverr_d = regdisp_root_map__upstream__err;
          prdata_d  = is_wr_q ? '0 : regdisp_root_map__upstream__rd_data;
        end else if (timeout_hit) begin
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and captured transfer
  always_ff @(posedge regdisp_root_map_clk or negedge regdisp_root_map_rst_n) begin
    if (!regdisp_root_map_rst_n) begin
      upstream__regdisp_root_map__req_vld <= 1'b0;
      upstream__regdisp_root_map__wr_en   <= 1'b0;
      upstream__regdisp_root_map__rd_en   <= 1'b0;
      upstream__regdisp_root_map__addr    <= '0;
      upstream__regdisp_root_map__wr_data <= '0;
      is_wr_q                             <= 1'b0;
      apb.pready                          <= 1'b0;
      apb.pslverr                         <= 1'b0;
      apb.prdata                          <= '0;
    end else begin
      upstream__regdisp_root_map__req_vld <= req_vld_d;
      upstream__regdisp_root_map__wr_en   <= req_vld_d & apb.pwrite;
      upstream__regdisp_root_map__rd_en   <= req_vld_d & ~apb.pwrite;
      apb.pready                          <= pready_d;
      apb.pslverr                         <= pslverr_d;
      apb.prdata                          <= prdata_d;
      if ((state_q == S_IDLE) && setup) begin
        upstream__regdisp_root_map__addr    <= ADDR_WIDTH'(apb.paddr) + BASE_ADDR;
        upstream__regdisp_root_map__wr_data <= apb.pwdata;
        is_wr_q                             <= apb.pwrite;
      end
    end
  end

  // Timeout counter: held at 0 in IDLE, so it starts from 0 on entering REQ
  always_ff @(posedge regdisp_root_map_clk or negedge regdisp_root_map_rst_n) begin
    if (!regdisp_root_map_rst_n) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      cnt_q <= '0;
    end else if (in_access && !ack && (TIMEOUT_CYCLES != 0)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Soft reset is a plain re-time, independent of the FSM
  always_ff @(posedge regdisp_root_map_clk or negedge regdisp_root_map_rst_n) begin
    if (!regdisp_root_map_rst_n) begin
      upstream__regdisp_root_map__soft_rst <= 1'b0;
    end else begin
      upstream__regdisp_root_map__soft_rst <= sw_soft_rst;
    end
  end

endmodule

// File: tb/tb_apb_regdisp_root_bridge.sv
// tb_apb_regdisp_root_bridge
//   Directed and randomized APB transfers against two bridge instances that
//   share all inputs: dut_a (default base, short timeout) and dut_b (base near
//   the top of the 64-bit space, so the absolute address wraps). Expected
//   responses come from transfer-level rules: pready cycle from ack latency or
//   timeout, address from 64-bit modular addition.
module tb_apb_regdisp_root_bridge;

  localparam int unsigned TO     = 4;
  localparam logic [63:0] BASE_A = 64'h0000_0000_2000_0000;
  localparam logic [63:0] BASE_B = 64'hFFFF_FFFF_FFFF_FFF0;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b0;
  logic        sw_soft_rst = 1'b0;
  logic        ack_vld     = 1'b0;
  logic        ack_err     = 1'b0;
  logic [31:0] ack_rd      = '0;

  logic        req_a, wr_a, rd_a, srst_a;
  logic [63:0] addr_a;
  logic [31:0] wd_a;
  logic        req_b, wr_b, rd_b, srst_b;
  logic [63:0] addr_b;
  logic [31:0] wd_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  apb_regdisp_root_bridge_if #(.APB_ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
  apb_regdisp_root_bridge_if #(.APB_ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

  assign bus_b.psel    = bus_a.psel;
  assign bus_b.penable = bus_a.penable;
  assign bus_b.pwrite  = bus_a.pwrite;
  assign bus_b.paddr   = bus_a.paddr;
  assign bus_b.pwdata  = bus_a.pwdata;
  assign bus_b.pstrb   = bus_a.pstrb;

  apb_regdisp_root_bridge #(
    .APB_ADDR_WIDTH(32), .ADDR_WIDTH(64), .DATA_WIDTH(32),
    .BASE_ADDR(BASE_A), .TIMEOUT_CYCLES(TO)
  ) dut_a (
    .regdisp_root_map_clk                (clk),
    .regdisp_root_map_rst_n              (rst_n),
    .apb                                 (bus_a),
    .sw_soft_rst                         (sw_soft_rst),
    .upstream__regdisp_root_map__req_vld (req_a),
    .upstream__regdisp_root_map__addr    (addr_a),
    .upstream__regdisp_root_map__wr_en   (wr_a),
    .upstream__regdisp_root_map__rd_en   (rd_a),
    .upstream__regdisp_root_map__wr_data (wd_a),
    .upstream__regdisp_root_map__soft_rst(srst_a),
    .regdisp_root_map__upstream__ack_vld (ack_vld),
    .regdisp_root_map__upstream__err     (ack_err),
    .regdisp_root_map__upstream__rd_data (ack_rd)
  );

  apb_regdisp_root_bridge #(
    .APB_ADDR_WIDTH(32), .ADDR_WIDTH(64), .DATA_WIDTH(32),
    .BASE_ADDR(BASE_B), .TIMEOUT_CYCLES(TO)
  ) dut_b (
    .regdisp_root_map_clk                (clk),
    .regdisp_root_map_rst_n              (rst_n),
    .apb                                 (bus_b),
    .sw_soft_rst                         (sw_soft_rst),
    .upstream__regdisp_root_map__req_vld (req_b),
    .upstream__regdisp_root_map__addr    (addr_b),
    .upstream__regdisp_root_map__wr_en   (wr_b),
    .upstream__regdisp_root_map__rd_en   (rd_b),
    .upstream__regdisp_root_map__wr_data (wd_b),
    .upstream__regdisp_root_map__soft_rst(srst_b),
    .regdisp_root_map__upstream__ack_vld (ack_vld),
    .regdisp_root_map__upstream__err     (ack_err),
    .regdisp_root_map__upstream__rd_data (ack_rd)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input logic rdy, input logic [31:0] rd, input logic err);
    chk({tag, " pready_a"},  64'(bus_a.pready),  64'(rdy));
    chk({tag, " prdata_a"},  64'(bus_a.prdata),  64'(rd));
    chk({tag, " pslverr_a"}, 64'(bus_a.pslverr), 64'(err));
    chk({tag, " pready_b"},  64'(bus_b.pready),  64'(rdy));
    chk({tag, " prdata_b"},  64'(bus_b.prdata),  64'(rd));
    chk({tag, " pslverr_b"}, 64'(bus_b.pslverr), 64'(err));
  endtask

  task automatic chk_req(input string tag, input logic req, input logic wr, input logic rd);
    chk({tag, " req_vld_a"}, 64'(req_a), 64'(req));
    chk({tag, " wr_en_a"},   64'(wr_a),  64'(wr));
    chk({tag, " rd_en_a"},   64'(rd_a),  64'(rd));
    chk({tag, " req_vld_b"}, 64'(req_b), 64'(req));
    chk({tag, " wr_en_b"},   64'(wr_b),  64'(wr));
    chk({tag, " rd_en_b"},   64'(rd_b),  64'(rd));
  endtask

  // One APB transfer. ack_k >= 0 drives an ack in cycle T1+ack_k; ack_k < 0
  // means no ack at all. Expected pready cycle (counted from setup T0):
  // strobe error -> 1, ack before the timeout -> 2+ack_k, else 1+TO.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] pa,
                      input logic [31:0] wd, input logic [3:0] st, input int ack_k,
                      input logic aerr, input logic [31:0] ard);
    logic        serr;
    int          exp_c;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic        req_now;
    serr = wr && (st != 4'hF);
    if (serr) begin
      exp_c = 1; exp_err = 1'b1; exp_rd = '0;
    end else if (ack_k >= 0 && ack_k < int'(TO)) begin
      exp_c = 2 + ack_k; exp_err = aerr; exp_rd = wr ? 32'h0 : ard;
    end else begin
      exp_c = 1 + int'(TO); exp_err = 1'b1; exp_rd = '0;
    end

    @(posedge clk); #1;
    bus_a.psel = 1'b1; bus_a.penable = 1'b0; bus_a.pwrite = wr;
    bus_a.paddr = pa; bus_a.pwdata = wd; bus_a.pstrb = st;
    ack_vld = 1'b0; ack_err = 1'b0; ack_rd = $urandom;
    @(negedge clk);
    chk_resp({tag, " setup"}, 1'b0, 32'h0, 1'b0);

    for (int c = 1; c <= exp_c; c++) begin
      @(posedge clk); #1;
      bus_a.penable = 1'b1;
      if (!serr && (c - 1 == ack_k)) begin
        ack_vld = 1'b1; ack_err = aerr; ack_rd = ard;
      end else begin
        ack_vld = 1'b0; ack_err = 1'($urandom); ack_rd = $urandom;
      end
      @(negedge clk);
      req_now = (c == 1) && !serr;
      chk_req(tag, req_now, req_now && wr, req_now && !wr);
      chk({tag, " addr_a"}, addr_a, 64'(pa) + BASE_A);
      chk({tag, " addr_b"}, addr_b, 64'(pa) + BASE_B);
      chk({tag, " wr_data_a"}, 64'(wd_a), 64'(wd));
      chk({tag, " wr_data_b"}, 64'(wd_b), 64'(wd));
      if (c == exp_c) chk_resp(tag, 1'b1, exp_rd, exp_err);
      else            chk_resp(tag, 1'b0, 32'h0, 1'b0);
    end
  endtask

  // Bus idle for n cycles, with an unsolicited ack in cycle at (if 0 <= at < n)
  task automatic idle(input string tag, input int n, input int at);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      bus_a.psel = 1'b0; bus_a.penable = 1'b0;
      ack_vld = (c == at); ack_err = 1'b1; ack_rd = $urandom;
      @(negedge clk);
      chk_resp(tag, 1'b0, 32'h0, 1'b0);
      chk_req(tag, 1'b0, 1'b0, 1'b0);
    end
    ack_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.psel = 1'b0; bus_a.penable = 1'b0; bus_a.pwrite = 1'b0;
    bus_a.paddr = '0; bus_a.pwdata = '0; bus_a.pstrb = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_resp("reset", 1'b0, 32'h0, 1'b0);
    chk_req("reset", 1'b0, 1'b0, 1'b0);
    chk("reset addr_a", addr_a, 64'h0);
    chk("reset soft_rst_a", 64'(srst_a), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Read into the dispatch range, ack two cycles after the request
    xfer("read_ack2", 1'b0, 32'h0000_0010, 32'h0, 4'hF, 2, 1'b0, 32'hCAFE_F00D);
    // Write with same-cycle ack
    xfer("write_ack0", 1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF, 0, 1'b0, 32'hDEAD_BEEF);
    // Timeout, then a late ack in T7, then a normal read
    xfer("timeout", 1'b0, 32'h0000_0008, 32'h0, 4'hF, -1, 1'b0, 32'h0);
    idle("stray_after_timeout", 3, 1);
    xfer("read_after_stray", 1'b0, 32'h0000_000C, 32'h0, 4'hF, 1, 1'b0, 32'h0BAD_CAFE);
    // Partial strobe
    xfer("partial_strobe", 1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 4'h3, 0, 1'b0, 32'h0);
    // Downstream error; dut_b checks the wrapped address 0x10
    xfer("downstream_err", 1'b0, 32'h0000_0020, 32'h0, 4'hF, 1, 1'b1, 32'h5555_AAAA);
    // Ack in the same cycle the timeout would fire: ack wins
    xfer("ack_vs_timeout", 1'b0, 32'h0000_0030, 32'h0, 4'hF, int'(TO) - 1, 1'b0, 32'h7777_1111);
    // Read strobe value is irrelevant
    xfer("read_partial_strb", 1'b0, 32'h0000_0040, 32'h0, 4'h1, 0, 1'b0, 32'h1357_9BDF);
    idle("idle", 2, -1);

    // Reset while waiting for ack
    @(posedge clk); #1;
    bus_a.psel = 1'b1; bus_a.penable = 1'b0; bus_a.pwrite = 1'b0;
    bus_a.paddr = 32'h0000_0044; bus_a.pstrb = 4'hF;
    @(posedge clk); #1;
    bus_a.penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_resp("rst_in_wait", 1'b0, 32'h0, 1'b0);
    chk_req("rst_in_wait", 1'b0, 1'b0, 1'b0);
    chk("rst_in_wait addr_a", addr_a, 64'h0);
    chk("rst_in_wait addr_b", addr_b, 64'h0);
    chk("rst_in_wait wr_data_a", 64'(wd_a), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_a.psel = 1'b0; bus_a.penable = 1'b0;
    idle("ack_after_reset", 4, 1);

    // Soft reset re-time
    @(posedge clk); #1;
    sw_soft_rst = 1'b1;
    @(negedge clk);
    chk("soft_rst t0 a", 64'(srst_a), 64'h0);
    @(posedge clk); #1;
    sw_soft_rst = 1'b0;
    @(negedge clk);
    chk("soft_rst t1 a", 64'(srst_a), 64'h1);
    chk("soft_rst t1 b", 64'(srst_b), 64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("soft_rst t2 a", 64'(srst_a), 64'h0);

    // Randomized transfers
    for (int i = 0; i < 30; i++) begin
      logic        wr;
      logic [31:0] pa;
      logic [3:0]  st;
      int          k;
      wr = 1'($urandom);
      pa = $urandom;
      st = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      k  = int'($urandom_range(0, TO));
      if (k == int'(TO)) k = -1;
      xfer("random", wr, pa, $urandom, st, k, 1'($urandom), $urandom);
      if ($urandom_range(0, 2) == 0) idle("random_idle", 2, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
